// File: rtl/mult_rs_if.sv
// mult_rs_if
// Bundles the reservation-station traffic for the multiply unit: the issue
// port from the front end, the common data bus broadcast, the busy
// indication from the multiplier, and the registered dispatch payload.
//
// Signals:
//   flush                         discard every held entry and pending dispatch
//   issue_valid/operand/depvals/deptags/depready/wbs/flags/robid
//                                 instruction offered for insertion
//   rs_full, rs_count             occupancy (full is combinational)
//   cdb_valid/cdb_id/cdb_val      result broadcast used for operand wakeup
//   fu_busy                       multiplier cannot accept work
//   input_transmit                one-cycle dispatch strobe
//   operand/wbs/flags/depvals/robid  dispatch payload, held between dispatches
//
// Modports: master drives issue/cdb/busy/flush, slave is the station itself.

interface mult_rs_if #(
  parameter int ENTRIES = 4
);

  localparam int CNTW = $clog2(ENTRIES + 1);

  logic            flush;
  logic            issue_valid;
  logic [7:0]      issue_operand;
  logic [1:0][7:0] issue_depvals;
  logic [1:0][3:0] issue_deptags;
  logic [1:0]      issue_depready;
  logic [7:0]      issue_wbs;
  logic [7:0]      issue_flags;
  logic [3:0]      issue_robid;
  logic            rs_full;
  logic [CNTW-1:0] rs_count;
  logic            cdb_valid;
  logic [3:0]      cdb_id;
  logic [7:0]      cdb_val;
  logic            fu_busy;
  logic            input_transmit;
  logic [7:0]      operand;
  logic [7:0]      wbs;
  logic [7:0]      flags;
  logic [1:0][7:0] depvals;
  logic [3:0]      robid;

  modport master (
    output flush, issue_valid, issue_operand, issue_depvals, issue_deptags,
           issue_depready, issue_wbs, issue_flags, issue_robid,
           cdb_valid, cdb_id, cdb_val, fu_busy,
    input  rs_full, rs_count, input_transmit, operand, wbs, flags, depvals, robid
  );

  modport slave (
    input  flush, issue_valid, issue_operand, issue_depvals, issue_deptags,
           issue_depready, issue_wbs, issue_flags, issue_robid,
           cdb_valid, cdb_id, cdb_val, fu_busy,
    output rs_full, rs_count, input_transmit, operand, wbs, flags, depvals, robid
  );

endinterface

// File: rtl/mult_rs.sv
// mult_rs
// Reservation station in front of the multiplier. Instructions are written
// into a free slot, wait until both source operands are valid (either at
// issue or through a CDB broadcast), and are dispatched oldest-first to the
// multiplier whenever it is idle. Each dispatch raises input_transmit for
// exactly one cycle while the payload registers hold the selected entry.
//
// Ports:
//   clk   sole clock, rising edge
//   rst   synchronous active-high reset, overrides everything
//   bus   mult_rs_if slave modport (issue, CDB, fu_busy, flush, dispatch)

module mult_rs #(
  parameter int ENTRIES = 4
) (
  input  logic     clk,
  input  logic     rst,
  mult_rs_if.slave bus
);

  localparam int IDXW = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;
  localparam int CNTW = $clog2(ENTRIES + 1);

  logic [ENTRIES-1:0] r_valid;
  logic [7:0]         r_operand [ENTRIES];
  logic [1:0][7:0]    r_val     [ENTRIES];
  logic [1:0][3:0]    r_tag     [ENTRIES];
  logic [1:0]         r_rdy     [ENTRIES];
  logic [7:0]         r_wbs     [ENTRIES];
  logic [7:0]         r_flags   [ENTRIES];
  logic [3:0]         r_robid   [ENTRIES];
  logic [IDXW-1:0]    r_age     [ENTRIES];
  logic [CNTW-1:0]    r_count;

  logic               r_transmit;
  logic [7:0]         r_outOperand;
  logic [7:0]         r_outWbs;
  logic [7:0]         r_outFlags;
  logic [1:0][7:0]    r_outDepvals;
  logic [3:0]         r_outRobid;

  logic               w_full;
  logic               w_issue;
  logic [IDXW-1:0]    w_freeIdx;
  logic [ENTRIES-1:0] w_cand;
  logic               w_anyCand;
  logic [IDXW-1:0]    w_selIdx;
  logic [IDXW-1:0]    w_bestAge;
  logic               w_dispatch;
  logic [1:0][7:0]    w_newVal;
  logic [1:0]         w_newRdy;
  logic [IDXW-1:0]    w_newAge;

  // Full looks only at the pre-edge valid bits, so a slot vacated by a
  // dispatch on this same edge cannot be refilled until the next edge.
  assign w_full  = &r_valid;
  assign w_issue = bus.issue_valid & ~w_full;

  // Walk from the top index down so the lowest free slot is the last one
  // written and therefore wins.
  always_comb begin
    w_freeIdx = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (!r_valid[i]) begin
        w_freeIdx = IDXW'(i);
      end
    end
  end

  // An entry may dispatch once both sources were ready before this edge.
  // Among those, the lowest age rank (the oldest instruction) is chosen.
  // Age ranks of valid entries are always distinct, so there is no tie.
  always_comb begin
    w_cand    = '0;
    w_anyCand = 1'b0;
    w_selIdx  = '0;
    w_bestAge = '1;
    for (int i = 0; i < ENTRIES; i++) begin
      w_cand[i] = r_valid[i] & r_rdy[i][0] & r_rdy[i][1];
      if (w_cand[i] && (!w_anyCand || (r_age[i] < w_bestAge))) begin
        w_anyCand = 1'b1;
        w_selIdx  = IDXW'(i);
        w_bestAge = r_age[i];
      end
    end
  end

  // Blocking on r_transmit forces at least one idle cycle between two
  // dispatches, which is what gives the multiplier its two-cycle spacing.
  assign w_dispatch = ~bus.fu_busy & ~r_transmit & w_anyCand;

  // A source that is not ready at issue can still be satisfied by a CDB
  // broadcast arriving on the same edge; without this bypass the entry would
  // miss that broadcast forever.
  always_comb begin
    w_newVal = bus.issue_depvals;
    w_newRdy = bus.issue_depready;
    for (int s = 0; s < 2; s++) begin
      if (!bus.issue_depready[s] && bus.cdb_valid &&
          (bus.issue_deptags[s] == bus.cdb_id)) begin
        w_newVal[s] = bus.cdb_val;
        w_newRdy[s] = 1'b1;
      end
    end
  end

  // The new entry is the youngest. If an older entry leaves on the same
  // edge every rank shifts down by one, so the newcomer lands one lower.
  assign w_newAge = w_dispatch ? IDXW'(r_count - CNTW'(1)) : IDXW'(r_count);

  // Main state update. Reset clears everything including the payload;
  // flush drops all entries and any strobe but leaves the payload as it was.
  // Otherwise wakeup, dispatch and issue are all applied on the same edge:
  // they never touch the same slot, because issue only writes a slot that
  // was free before the edge while wakeup and dispatch only touch occupied ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid      <= '0;
      r_count      <= '0;
      r_transmit   <= 1'b0;
      r_outOperand <= '0;
      r_outWbs     <= '0;
      r_outFlags   <= '0;
      r_outDepvals <= '0;
      r_outRobid   <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        r_operand[i] <= '0;
        r_val[i]     <= '0;
        r_tag[i]     <= '0;
        r_rdy[i]     <= '0;
        r_wbs[i]     <= '0;
        r_flags[i]   <= '0;
        r_robid[i]   <= '0;
        r_age[i]     <= '0;
      end
    end else if (bus.flush) begin
      r_valid    <= '0;
      r_count    <= '0;
      r_transmit <= 1'b0;
    end else begin
      r_transmit <= w_dispatch;
      r_count    <= r_count + CNTW'(w_issue) - CNTW'(w_dispatch);

      for (int i = 0; i < ENTRIES; i++) begin
        for (int s = 0; s < 2; s++) begin
          if (r_valid[i] && !r_rdy[i][s] && bus.cdb_valid &&
              (r_tag[i][s] == bus.cdb_id)) begin
            r_val[i][s] <= bus.cdb_val;
            r_rdy[i][s] <= 1'b1;
          end
        end
        if (w_dispatch && r_valid[i] && (r_age[i] > w_bestAge)) begin
          r_age[i] <= r_age[i] - IDXW'(1);
        end
      end

      if (w_dispatch) begin
        r_valid[w_selIdx] <= 1'b0;
        r_outOperand      <= r_operand[w_selIdx];
        r_outWbs          <= r_wbs[w_selIdx];
        r_outFlags        <= r_flags[w_selIdx];
        r_outDepvals      <= r_val[w_selIdx];
        r_outRobid        <= r_robid[w_selIdx];
      end

      if (w_issue) begin
        r_valid[w_freeIdx]   <= 1'b1;
        r_operand[w_freeIdx] <= bus.issue_operand;
        r_val[w_freeIdx]     <= w_newVal;
        r_tag[w_freeIdx]     <= bus.issue_deptags;
        r_rdy[w_freeIdx]     <= w_newRdy;
        r_wbs[w_freeIdx]     <= bus.issue_wbs;
        r_flags[w_freeIdx]   <= bus.issue_flags;
        r_robid[w_freeIdx]   <= bus.issue_robid;
        r_age[w_freeIdx]     <= w_newAge;
      end
    end
  end

  assign bus.rs_full        = w_full;
  assign bus.rs_count       = r_count;
  assign bus.input_transmit = r_transmit;
  assign bus.operand        = r_outOperand;
  assign bus.wbs            = r_outWbs;
  assign bus.flags          = r_outFlags;
  assign bus.depvals        = r_outDepvals;
  assign bus.robid          = r_outRobid;

endmodule

// File: doc/mult_rs.md
MULT_RS -- requirements
Module: mult_rs

Interface
REQ-001 Parameter: ENTRIES, default 4, number of reservation-station slots; RTL and bench verified at 4 only.
REQ-002 Clocking: one clock; reset is synchronous and active-high.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous active-high reset.
REQ-005 flush  input  1  synchronous discard of all entries and any pending dispatch.
REQ-006 issue_valid  input  1  new multiply instruction offered this cycle.
REQ-007 issue_operand  input  8  opaque operand field, carried unchanged.
REQ-008 issue_depvals  input  [1:0][7:0]  source values, meaningful only where issue_depready bit set.
REQ-009 issue_deptags  input  [1:0][3:0]  ROB id producing each not-ready source.
REQ-010 issue_depready  input  2  per-source value-valid bit.
REQ-011 issue_wbs, issue_flags  input  8 each  carried unchanged.
REQ-012 issue_robid  input  4  ROB id of the instruction.
REQ-013 rs_full  output  1  combinational; all entries valid.
REQ-014 rs_count  output  3  registered count of valid entries.
REQ-015 cdb_valid  input  1  CDB broadcast valid (driven by the FU cdb_transmit_out network).
REQ-016 cdb_id, cdb_val  input  4, 8  broadcast ROB id and value.
REQ-017 fu_busy  input  1  multfu busy.
REQ-018 input_transmit  output  1  registered one-cycle dispatch strobe to multfu.
REQ-019 operand, wbs, flags  output  8 each; depvals  output  [1:0][7:0]; robid  output  4  registered dispatch payload, valid while input_transmit=1.

Function
REQ-020 Per-entry state: valid, operand, val[1:0], tag[1:0], rdy[1:0], wbs, flags, robid, age rank (0 = oldest).
REQ-021 Issue: issue_valid=1 and rs_full=0 at edge writes lowest-index free entry, age rank = current rs_count.
REQ-022 issue_valid while rs_full=1 is ignored (no state change); rs_full uses pre-edge state, so a slot freed by dispatch at the same edge is not reusable that edge.
REQ-023 Wakeup: each valid entry source with rdy=0 and tag==cdb_id on cdb_valid=1 captures cdb_val and sets rdy at that edge; both sources may wake on one broadcast.
REQ-024 Issue bypass: an issuing source with depready=0 and deptag==cdb_id while cdb_valid=1 is written with cdb_val, rdy=1.
REQ-025 Candidate: valid entry with both rdy=1 in pre-edge state; a source woken at edge N is eligible from edge N+1.
REQ-026 Dispatch condition: fu_busy=0, input_transmit=0, at least one candidate; select candidate with lowest age rank.
REQ-027 On dispatch edge: payload registers load the selected entry, input_transmit<=1, entry invalidated, younger entries' age ranks decrement by 1.
REQ-028 input_transmit deasserts the following edge unconditionally (exactly one cycle high); payload outputs hold until next dispatch.
REQ-029 Latency: ready instruction issued at edge N with fu_busy=0 gives input_transmit=1 from edge N+1 to N+2; minimum dispatch spacing 2 cycles.
REQ-030 Simultaneous issue and dispatch: both applied; rs_count unchanged; new entry takes rank rs_count-1.
REQ-031 flush=1 at edge: all entries invalid, rs_count<=0, input_transmit<=0; issue and wakeup that edge discarded; flush has priority over everything but rst.

Reset
REQ-032 rst=1 at edge: all entries invalid, rs_count=0, rs_full=0, input_transmit=0, operand/depvals/wbs/flags/robid=0; rst overrides flush, issue, wakeup, dispatch.
REQ-033 Reset mid-operation (entries pending, input_transmit high) clears all state the same edge; no dispatch follows.

Verification
REQ-034 Ready issue depvals {5,10}, robid 1, wbs B1, fu_busy=0 at edge N -> input_transmit=1 only for cycle N+1..N+2, depvals {5,10}, robid 1, wbs B1.
REQ-035 Issue src0 tag 3 not ready, src1=8; cdb_valid id 3 val 7 at edge N+2 -> dispatch at edge N+3, depvals {7,8}.
REQ-036 fu_busy=1, issue robids 1..5 -> rs_full=1, rs_count=4, robid 5 dropped; drop fu_busy -> dispatches robid 1,2,3,4 in order, none closer than 2 cycles.
REQ-037 Older entry robid 2 waiting on tag 9, younger robid 3 ready -> robid 3 dispatches first; cdb id 9 then dispatches robid 2.
REQ-038 Issue with deptag 6 not ready while cdb_valid id 6 val 25 same edge -> entry captured ready, dispatched next edge with value 25.
REQ-039 Three entries pending, flush at edge N -> rs_count=0 and no input_transmit after N; rst mid-dispatch -> all outputs 0 next cycle.
